// File: rtl/best_arr_streamer.sv
// Streams the best-leaf results out of the result memory to the output FIFO:
// first every index word in blocked scan order, then every distance as lo/hi halves.
module best_arr_streamer #(
    parameter int DATA_WIDTH = 11,
    parameter int ROW_SIZE   = 26,
    parameter int COL_SIZE   = 19,
    parameter int BLOCKING   = 4,
    parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    parameter int AW         = $clog2(NUM_QUERYS)
) (
    input  logic                    io_clk,
    input  logic                    io_rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [AW-1:0]           rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_idx,
    input  logic [2*DATA_WIDTH-1:0] rd_dist,
    output logic                    out_fifo_wenq,
    output logic [DATA_WIDTH-1:0]   out_fifo_wdata,
    input  logic                    out_fifo_wfull_n
);

    localparam int HALF = ROW_SIZE / 2;
    localparam int XN   = (HALF + BLOCKING - 1) / BLOCKING;
    localparam int XW   = (XN > 1) ? $clog2(XN) : 1;
    localparam int YW   = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
    localparam int XIW  = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

    typedef enum logic [2:0] {IDLE, RD, LAT, SEND_LO, SEND_HI} state_t;
    typedef enum logic {PH_IDX, PH_DIST} phase_t;

    state_t                  state_reg, state_next;
    phase_t                  phase_reg, phase_next;
    logic                    px_reg, px_next;
    logic [XW-1:0]           x_reg, x_next;
    logic [YW-1:0]           y_reg, y_next;
    logic [XIW-1:0]          xi_reg, xi_next;
    logic [DATA_WIDTH-1:0]   hold_idx_reg, hold_idx_next;
    logic [2*DATA_WIDTH-1:0] hold_dist_reg, hold_dist_next;

    logic                    px_adv;
    logic [XW-1:0]           x_adv;
    logic [YW-1:0]           y_adv;
    logic [XIW-1:0]          xi_adv;
    logic                    last_entry;
    logic                    advance;
    logic                    done_int;
    logic [AW-1:0]           addr_calc;

    // Next valid entry in scan order; columns past the half row are skipped
    // here so a skipped (x,xi) never costs a cycle.
    always_comb begin
        px_adv     = px_reg;
        x_adv      = x_reg;
        y_adv      = y_reg;
        xi_adv     = xi_reg;
        last_entry = 1'b0;
        if ((xi_reg != XIW'(BLOCKING - 1)) &&
            (int'(x_reg) * BLOCKING + int'(xi_reg) + 1 < HALF)) begin
            xi_adv = xi_reg + XIW'(1);
        end else begin
            xi_adv = '0;
            if (y_reg != YW'(COL_SIZE - 1)) begin
                y_adv = y_reg + YW'(1);
            end else begin
                y_adv = '0;
                if (x_reg != XW'(XN - 1)) begin
                    x_adv = x_reg + XW'(1);
                end else begin
                    x_adv = '0;
                    if (!px_reg) begin
                        px_adv = 1'b1;
                    end else begin
                        last_entry = 1'b1;
                    end
                end
            end
        end
    end

    assign addr_calc = AW'(px_reg) * AW'(HALF) + AW'(y_reg) * AW'(ROW_SIZE)
                     + AW'(x_reg) * AW'(BLOCKING) + AW'(xi_reg);

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        px_next        = px_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        xi_next        = xi_reg;
        hold_idx_next  = hold_idx_reg;
        hold_dist_next = hold_dist_reg;
        advance        = 1'b0;
        done_int       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RD;
                    phase_next = PH_IDX;
                    px_next    = 1'b0;
                    x_next     = '0;
                    y_next     = '0;
                    xi_next    = '0;
                end
            end
            RD: state_next = LAT;
            LAT: begin
                hold_idx_next  = rd_idx;
                hold_dist_next = rd_dist;
                state_next     = SEND_LO;
            end
            SEND_LO: begin
                if (out_fifo_wfull_n) begin
                    if (phase_reg == PH_DIST) begin
                        state_next = SEND_HI;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            SEND_HI: begin
                if (out_fifo_wfull_n) begin
                    advance = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (advance) begin
            if (last_entry) begin
                px_next = 1'b0;
                x_next  = '0;
                y_next  = '0;
                xi_next = '0;
                if (phase_reg == PH_IDX) begin
                    phase_next = PH_DIST;
                    state_next = RD;
                end else begin
                    state_next = IDLE;
                    done_int   = 1'b1;
                end
            end else begin
                px_next    = px_adv;
                x_next     = x_adv;
                y_next     = y_adv;
                xi_next    = xi_adv;
                state_next = RD;
            end
        end
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state_reg     <= IDLE;
            phase_reg     <= PH_IDX;
            px_reg        <= 1'b0;
            x_reg         <= '0;
            y_reg         <= '0;
            xi_reg        <= '0;
            hold_idx_reg  <= '0;
            hold_dist_reg <= '0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            px_reg        <= px_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            xi_reg        <= xi_next;
            hold_idx_reg  <= hold_idx_next;
            hold_dist_reg <= hold_dist_next;
        end
    end

    // Outputs decode the registered state, so reset clears them immediately.
    assign busy          = (state_reg != IDLE);
    assign rd_en         = (state_reg == RD);
    assign rd_addr       = rd_en ? addr_calc : '0;
    assign out_fifo_wenq = ((state_reg == SEND_LO) || (state_reg == SEND_HI)) && out_fifo_wfull_n;
    assign done          = done_int;

    always_comb begin
        out_fifo_wdata = '0;
        if (state_reg == SEND_LO) begin
            out_fifo_wdata = (phase_reg == PH_IDX) ? hold_idx_reg
                                                   : hold_dist_reg[DATA_WIDTH-1:0];
        end else if (state_reg == SEND_HI) begin
            out_fifo_wdata = hold_dist_reg[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_best_arr_streamer.sv
// Scoreboard bench for best_arr_streamer: expected words are queued from a
// scan-order reference model and a monitor pops/compares each accepted word.
module tb_best_arr_streamer;

    localparam int DW     = 11;
    localparam int ROW    = 26;
    localparam int COL    = 19;
    localparam int BLK    = 4;
    localparam int NQ     = ROW * COL;
    localparam int AW     = $clog2(NQ);
    localparam int HALF   = ROW / 2;
    localparam int NWORDS = 3 * NQ;

    logic            io_clk = 1'b0;
    logic            io_rst_n = 1'b1;
    logic            start = 1'b0;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_idx = '0;
    logic [2*DW-1:0] rd_dist = '0;
    logic            out_fifo_wenq;
    logic [DW-1:0]   out_fifo_wdata;
    logic            out_fifo_wfull_n = 1'b1;

    best_arr_streamer dut (
        .io_clk           (io_clk),
        .io_rst_n         (io_rst_n),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_idx           (rd_idx),
        .rd_dist          (rd_dist),
        .out_fifo_wenq    (out_fifo_wenq),
        .out_fifo_wdata   (out_fifo_wdata),
        .out_fifo_wfull_n (out_fifo_wfull_n)
    );

    initial forever #5 io_clk = ~io_clk;

    int              errors = 0;
    int              checks = 0;
    int              acc_cnt = 0;
    int              done_cnt = 0;
    int              done_at = 0;
    bit              bp_rand = 1'b0;
    logic [DW-1:0]   got [NWORDS];
    logic [DW-1:0]   exp_q [$];
    logic [DW-1:0]   idx_mem [NQ];
    logic [2*DW-1:0] dist_mem [NQ];
    int              order [$];
    logic [DW-1:0]   mon_exp;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Scan order straight from the rule: px, x, y, xi nesting, half-row columns only.
    task automatic build_order();
        order.delete();
        for (int px = 0; px < 2; px++)
            for (int x = 0; x < (HALF + BLK - 1) / BLK; x++)
                for (int y = 0; y < COL; y++)
                    for (int xi = 0; xi < BLK; xi++)
                        if (x * BLK + xi < HALF)
                            order.push_back(px * HALF + y * ROW + x * BLK + xi);
    endtask

    task automatic push_expected();
        logic [2*DW-1:0] d;
        exp_q.delete();
        foreach (order[i]) exp_q.push_back(idx_mem[order[i]]);
        foreach (order[i]) begin
            d = dist_mem[order[i]];
            exp_q.push_back(d[DW-1:0]);
            exp_q.push_back(d[2*DW-1:DW]);
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < NQ; a++) begin
            idx_mem[a]  = DW'($urandom);
            dist_mem[a] = (2*DW)'($urandom);
        end
    endtask

    // Result memory: data appears the cycle after rd_en, garbage otherwise.
    initial forever begin
        @(posedge io_clk);
        if (rd_en) begin
            rd_idx  <= idx_mem[rd_addr];
            rd_dist <= dist_mem[rd_addr];
        end else begin
            rd_idx  <= DW'($urandom);
            rd_dist <= (2*DW)'($urandom);
        end
    end

    initial forever begin
        @(posedge io_clk);
        #1;
        if (bp_rand) out_fifo_wfull_n = ($urandom_range(0, 3) != 0);
    end

    // Monitor: every accepted word is popped from the scoreboard and compared.
    initial forever begin
        @(negedge io_clk);
        if (io_rst_n) begin
            if (out_fifo_wenq) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word[%0d]: got %0d required no word", acc_cnt, out_fifo_wdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (out_fifo_wdata !== mon_exp || !out_fifo_wfull_n) begin
                        errors++;
                        $display("FAIL word[%0d]: got %0d (wfull_n=%0b) required %0d (wfull_n=1)",
                                 acc_cnt, out_fifo_wdata, out_fifo_wfull_n, mon_exp);
                    end
                end
                if (acc_cnt < NWORDS) got[acc_cnt] = out_fifo_wdata;
                acc_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_at = acc_cnt;
            end
        end
    end

    task automatic start_and_latency(output int lat);
        bit seen;
        seen = 1'b0;
        @(posedge io_clk);
        #1 start = 1'b1;
        @(posedge io_clk);
        #1 start = 1'b0;
        lat = 1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge io_clk);
            if (out_fifo_wenq) seen = 1'b1;
            else lat++;
        end
        if (!seen) $display("FAIL first_word_timeout: got no word required one within 50 cycles");
    endtask

    task automatic wait_words(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10000 && !ok; i++) begin
            @(negedge io_clk);
            #1;
            if (acc_cnt >= n) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL word_wait: got %0d words required %0d", acc_cnt, n);
        end
    endtask

    task automatic wait_done(input int budget);
        int base;
        bit ok;
        base = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge io_clk);
            #1;
            if (done_cnt != base) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout: got no done required one within %0d cycles", budget);
        end
    endtask

    task automatic end_of_stream_checks(input string tag);
        repeat (3) @(negedge io_clk);
        check({tag, "_word_count"}, acc_cnt, NWORDS);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_with_last"}, done_at, NWORDS);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
    endtask

    int lat;
    logic [2*DW-1:0] dlast;

    initial begin
        build_order();

        #1 io_rst_n = 1'b0;
        #3;
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(done), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_wenq",  int'(out_fifo_wenq), 0);
        check("rst_wdata", int'(out_fifo_wdata), 0);
        repeat (2) @(posedge io_clk);
        #1 io_rst_n = 1'b1;

        // Stream A: idx[a]=a, directed stall in SEND_HI, start pulsed while busy.
        for (int a = 0; a < NQ; a++) begin
            idx_mem[a]  = DW'(a);
            dist_mem[a] = (2*DW)'($urandom);
        end
        dist_mem[0] = (2*DW)'((5 << DW) | 9);
        acc_cnt = 0; done_cnt = 0;
        push_expected();
        start_and_latency(lat);
        check("a_latency", lat, 3);
        wait_words(NQ + 1);
        @(posedge io_clk);
        #1 out_fifo_wfull_n = 1'b0;
        repeat (10) begin
            @(negedge io_clk);
            check("a_stall_wenq", int'(out_fifo_wenq), 0);
            check("a_stall_wdata", int'(out_fifo_wdata), 5);
        end
        @(posedge io_clk);
        #1 out_fifo_wfull_n = 1'b1;
        check("a_busy_mid", int'(busy), 1);
        @(posedge io_clk);
        #1 start = 1'b1;
        @(posedge io_clk);
        #1 start = 1'b0;
        wait_done(20000);
        end_of_stream_checks("a");
        check("a_idx0", int'(got[0]), 0);
        check("a_idx3", int'(got[3]), 3);
        check("a_idx4", int'(got[4]), 26);
        check("a_px0_x3_y0", int'(got[228]), 12);
        check("a_px1_first", int'(got[247]), 13);
        check("a_last_idx", int'(got[NQ-1]), 493);
        check("a_dist0_lo", int'(got[NQ]), 9);
        check("a_dist0_hi", int'(got[NQ+1]), 5);
        dlast = dist_mem[493];
        check("a_final_word", int'(got[NWORDS-1]), int'(dlast[2*DW-1:DW]));

        // Stream B: random contents, random backpressure.
        fill_random();
        acc_cnt = 0; done_cnt = 0;
        push_expected();
        bp_rand = 1'b1;
        start_and_latency(lat);
        wait_done(20000);
        bp_rand = 1'b0;
        @(posedge io_clk);
        #2 out_fifo_wfull_n = 1'b1;
        end_of_stream_checks("b");

        // Stream C: reset after 100 words, then a clean restart from entry 0.
        fill_random();
        acc_cnt = 0; done_cnt = 0;
        push_expected();
        start_and_latency(lat);
        wait_words(100);
        #2 io_rst_n = 1'b0;
        #1;
        check("c_rst_wenq",  int'(out_fifo_wenq), 0);
        check("c_rst_busy",  int'(busy), 0);
        check("c_rst_rd_en", int'(rd_en), 0);
        check("c_rst_done",  int'(done), 0);
        exp_q.delete();
        repeat (2) @(posedge io_clk);
        #1 io_rst_n = 1'b1;
        acc_cnt = 0; done_cnt = 0;
        push_expected();
        start_and_latency(lat);
        check("c_latency", lat, 3);
        check("c_first_word", int'(out_fifo_wdata), int'(idx_mem[0]));
        bp_rand = 1'b1;
        wait_done(20000);
        bp_rand = 1'b0;
        end_of_stream_checks("c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
